// File: rtl/rv_pkg.sv
// Shared widths and helpers for the ready/valid pipeline blocks.
// Both the pipeline register and the serializer use these defaults and checks.
package rv_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int BEAT_W_DEF = 8;

  // Number of narrow beats in a wide word. Returns 0 for a zero beat width.
  function automatic int ratio_of(input int in_w, input int out_w);
    return (out_w > 0) ? (in_w / out_w) : 0;
  endfunction

  // True when a wide word splits into a whole number of beats, at least two.
  function automatic bit widths_ok(input int in_w, input int out_w);
    return (out_w > 0) && (in_w % out_w == 0) && (ratio_of(in_w, out_w) >= 2);
  endfunction

endpackage

// File: rtl/rv_serializer.sv
// Splits each accepted IN_W-bit word into RATIO narrow beats, LSB slice first,
// and reloads on the last beat so back-to-back words stream with no bubble.
module rv_serializer
  import rv_pkg::*;
#(
  parameter  int IN_W  = DATA_W_DEF,
  parameter  int OUT_W = BEAT_W_DEF,
  localparam int RATIO = ratio_of(IN_W, OUT_W),
  localparam int CNT_W = $clog2(RATIO)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] out_idx
);

  if (!widths_ok(IN_W, OUT_W)) begin : g_bad_widths
    $error("rv_serializer: IN_W must be a multiple of OUT_W with at least two beats");
  end

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [IN_W-1:0]  sh;

  logic at_last;
  logic beat_fire;
  logic in_fire;

  assign at_last   = (cnt == LAST_IDX);
  assign beat_fire = busy && out_ready;
  // Depends only on state and out_ready, never on in_valid, so no loop with upstream.
  assign in_ready  = !busy || (out_ready && at_last);
  assign in_fire   = in_valid && in_ready;

  assign out_valid = busy;
  assign out_data  = sh[OUT_W-1:0];
  assign out_idx   = cnt;
  assign out_last  = busy && at_last;

  // NOTE: state registers use non-blocking assignments so every update in this
  // block sees the pre-edge values, just like the flops they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      sh   <= '0;
    end else if (in_fire) begin
      // Covers both the idle load and the reload on the last beat.
      busy <= 1'b1;
      cnt  <= '0;
      sh   <= in_data;
    end else if (beat_fire && at_last) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (beat_fire) begin
      cnt  <= cnt + CNT_W'(1);
      sh   <= sh >> OUT_W;
    end
  end

  a_stall_stable : assert property (
    @(posedge clk) disable iff (!rst_n)
    out_valid && !out_ready |=> $stable({out_valid, out_data, out_idx, out_last})
  ) else $error("rv_serializer: beat changed while stalled");

  a_cnt_range : assert property (
    @(posedge clk) disable iff (!rst_n)
    cnt <= LAST_IDX
  ) else $error("rv_serializer: beat counter out of range");

endmodule

// File: tb/tb_rv_serializer.sv
// Directed bench for rv_serializer (32-bit words, 8-bit beats): reset, streaming,
// backpressure, mid-word reset and idle-gap cases with hand-computed beats.
module tb_rv_serializer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_idx;

  int total = 0;
  int bad   = 0;

  rv_serializer #(.IN_W(32), .OUT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .out_idx  (out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [7:0] d, input logic [1:0] idx,
                      input logic last, input logic rdy);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".data"},  32'(out_data),  32'(d));
    check({tag, ".idx"},   32'(out_idx),   32'(idx));
    check({tag, ".last"},  32'(out_last),  32'(last));
    check({tag, ".ready"}, 32'(in_ready),  32'(rdy));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    #2;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.last",  32'(out_last),  32'd0);
    check("rst.idx",   32'(out_idx),   32'd0);
    check("rst.data",  32'(out_data),  32'd0);
    check("rst.ready", 32'(in_ready),  32'd1);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    check("post_rst.valid", 32'(out_valid), 32'd0);

    // Single word, X on in_data once in_valid drops
    in_valid  = 1'b1;
    in_data   = 32'hA1B2C3D4;
    out_ready = 1'b1;
    check("single.ready_idle", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_data  = 'x;
    beat("single.b0", 8'hD4, 2'd0, 1'b0, 1'b0);
    step();
    beat("single.b1", 8'hC3, 2'd1, 1'b0, 1'b0);
    step();
    beat("single.b2", 8'hB2, 2'd2, 1'b0, 1'b0);
    step();
    beat("single.b3", 8'hA1, 2'd3, 1'b1, 1'b1);
    step();
    check("single.done", 32'(out_valid), 32'd0);

    // Back-to-back words with no gap
    in_valid = 1'b1;
    in_data  = 32'h03020100;
    step();
    in_data = 32'h07060504;
    beat("b2b.b0", 8'h00, 2'd0, 1'b0, 1'b0);
    step();
    beat("b2b.b1", 8'h01, 2'd1, 1'b0, 1'b0);
    step();
    beat("b2b.b2", 8'h02, 2'd2, 1'b0, 1'b0);
    step();
    beat("b2b.b3", 8'h03, 2'd3, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    in_data  = '0;
    beat("b2b.b4", 8'h04, 2'd0, 1'b0, 1'b0);
    step();
    beat("b2b.b5", 8'h05, 2'd1, 1'b0, 1'b0);
    step();
    beat("b2b.b6", 8'h06, 2'd2, 1'b0, 1'b0);
    step();
    beat("b2b.b7", 8'h07, 2'd3, 1'b1, 1'b1);
    step();
    check("b2b.done", 32'(out_valid), 32'd0);

    // Backpressure at idx 1, with a second word waiting upstream
    in_valid = 1'b1;
    in_data  = 32'hA1B2C3D4;
    step();
    in_valid = 1'b0;
    beat("bp.b0", 8'hD4, 2'd0, 1'b0, 1'b0);
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEADBEEF;
    beat("bp.hold0", 8'hC3, 2'd1, 1'b0, 1'b0);
    step();
    beat("bp.hold1", 8'hC3, 2'd1, 1'b0, 1'b0);
    step();
    beat("bp.hold2", 8'hC3, 2'd1, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    beat("bp.b2", 8'hB2, 2'd2, 1'b0, 1'b0);
    step();
    beat("bp.b3", 8'hA1, 2'd3, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    in_data  = '0;
    beat("bp.w2b0", 8'hEF, 2'd0, 1'b0, 1'b0);
    step();
    beat("bp.w2b1", 8'hBE, 2'd1, 1'b0, 1'b0);
    step();
    beat("bp.w2b2", 8'hAD, 2'd2, 1'b0, 1'b0);
    step();
    beat("bp.w2b3", 8'hDE, 2'd3, 1'b1, 1'b1);
    step();
    check("bp.done", 32'(out_valid), 32'd0);

    // Reset in the middle of a word
    in_valid = 1'b1;
    in_data  = 32'hA1B2C3D4;
    step();
    in_valid = 1'b0;
    beat("mrst.b0", 8'hD4, 2'd0, 1'b0, 1'b0);
    step();
    beat("mrst.b1", 8'hC3, 2'd1, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("mrst.valid", 32'(out_valid), 32'd0);
    check("mrst.idx",   32'(out_idx),   32'd0);
    check("mrst.last",  32'(out_last),  32'd0);
    check("mrst.ready", 32'(in_ready),  32'd1);
    step();
    rst_n = 1'b1;
    step();
    check("mrst.idle", 32'(out_valid), 32'd0);
    step();
    check("mrst.idle2", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_data  = 32'h11223344;
    step();
    in_valid = 1'b0;
    beat("mrst.w2b0", 8'h44, 2'd0, 1'b0, 1'b0);
    step();
    beat("mrst.w2b1", 8'h33, 2'd1, 1'b0, 1'b0);
    step();
    beat("mrst.w2b2", 8'h22, 2'd2, 1'b0, 1'b0);
    step();
    beat("mrst.w2b3", 8'h11, 2'd3, 1'b1, 1'b1);

    // One-cycle gap before the next word
    step();
    check("gap.valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_data  = 32'hCAFEF00D;
    check("gap.ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    beat("gap.b0", 8'h0D, 2'd0, 1'b0, 1'b0);
    step();
    beat("gap.b1", 8'hF0, 2'd1, 1'b0, 1'b0);
    step();
    beat("gap.b2", 8'hFE, 2'd2, 1'b0, 1'b0);
    step();
    beat("gap.b3", 8'hCA, 2'd3, 1'b1, 1'b1);
    step();
    check("gap.done", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
